// File: rtl/bsg_decode_one_hot_buffered.sv
// Buffered binary-to-one-hot decoder: 2-entry index FIFO, decode at the head.
// Latency: 1 cycle from accepted index (v_i & ready_o) to v_o.
// Backpressure: ready_o drops when both entries are full, even if yumi_i is high.
// Optional macro BSG_DECODE_ONE_HOT_ERR_CNT_EN adds err_cnt_o, a saturating count of accepted out-of-range indices.
module bsg_decode_one_hot_buffered #(
    parameter int  width_p     = 128,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [lg_width_lp-1:0] addr_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     o,
    output logic                   err_o,
    input  logic                   yumi_i
`ifdef BSG_DECODE_ONE_HOT_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt_o
`endif
);

    // Entries hold the index plus its range flag; decoding happens only at the head.
    logic [1:0]             count_q, count_d;
    logic                   wptr_q, wptr_d;
    logic                   rptr_q, rptr_d;
    logic                   init_q, init_d;
    logic [lg_width_lp-1:0] addr_mem_q [2];
    logic [lg_width_lp-1:0] addr_mem_d [2];
    logic                   err_mem_q  [2];
    logic                   err_mem_d  [2];

    logic enq, deq, err_in;
    logic [lg_width_lp-1:0] addr_head;
    logic                   err_head;

    // init_q holds ready_o low until the first edge after reset release.
    assign ready_o   = init_q & (count_q != 2'd2);
    assign v_o       = (count_q != 2'd0);
    assign enq       = v_i & ready_o;
    assign deq       = yumi_i & v_o;
    // Extra MSB lets the compare see width_p itself; folds to 0 for power-of-two widths.
    assign err_in    = ({1'b0, addr_i} >= (lg_width_lp+1)'(width_p));
    assign addr_head = addr_mem_q[rptr_q];
    assign err_head  = err_mem_q[rptr_q];
    assign err_o     = v_o & err_head;

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        init_d    = 1'b1;
        addr_mem_d = addr_mem_q;
        err_mem_d  = err_mem_q;
        if (enq) begin
            addr_mem_d[wptr_q] = addr_i;
            err_mem_d[wptr_q]  = err_in;
            wptr_d             = ~wptr_q;
        end
        if (deq) begin
            rptr_d = ~rptr_q;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every stored entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q       <= 2'd0;
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            init_q        <= 1'b0;
            addr_mem_q[0] <= '0;
            addr_mem_q[1] <= '0;
            err_mem_q[0]  <= 1'b0;
            err_mem_q[1]  <= 1'b0;
        end else begin
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            init_q        <= init_d;
            addr_mem_q[0] <= addr_mem_d[0];
            addr_mem_q[1] <= addr_mem_d[1];
            err_mem_q[0]  <= err_mem_d[0];
            err_mem_q[1]  <= err_mem_d[1];
        end
    end

    // One-hot decode of the head; out-of-range or empty heads give all zeros.
    always_comb begin
        o = '0;
        for (int k = 0; k < width_p; k++) begin
            o[k] = v_o & ~err_head & (addr_head == lg_width_lp'(k));
        end
    end

`ifdef BSG_DECODE_ONE_HOT_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of accepted out-of-range indices.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (enq && err_in && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Counter register, cleared with the rest of the state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

`ifndef SYNTHESIS
    // Consumer must not take an entry that is not there.
    yumi_when_empty : assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));
`endif

endmodule
